// File: rtl/keymap_pkg.sv
// Shared keyboard definitions: action/direction encodings, per-player keymap, event layout.
package keymap_pkg;

  typedef enum logic [2:0] {
    ACT_UP    = 3'd0,
    ACT_DOWN  = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_BOMB  = 3'd4
  } action_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam int KEY_W       = 8;
  localparam int NUM_ACTIONS = 5;
  localparam int NUM_DIRS    = 4;
  localparam int DIR_W       = 3;
  localparam int PLAYER_W    = 1;
  localparam int ACTION_W    = 3;
  localparam int EV_W        = PLAYER_W + ACTION_W + 1;

  // P0: W S A D Space, P1: arrows and Enter (USB HID usage codes).
  localparam logic [KEY_W-1:0] KEYMAP [0:1][0:NUM_ACTIONS-1] = '{
    '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C},
    '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h28}
  };

  function automatic logic [EV_W-1:0] pack_event(input logic [PLAYER_W-1:0] player,
                                                 input logic [ACTION_W-1:0] action,
                                                 input logic is_press);
    return {player, action, is_press};
  endfunction

endpackage

// File: rtl/kt_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a pop frees a slot for a push in the same cycle.
module kt_sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_r == CW'(DEPTH));
  assign empty      = (count_r == {CW{1'b0}});
  assign do_pop     = pop_ready & ~empty;
  assign push_ready = ~full | do_pop;
  assign do_push    = push & push_ready;
  assign pop_valid  = ~empty;
  assign pop_data   = mem_r[rd_ptr_r];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keycode_tracker.sv
// Multi-slot, multi-player keycode decoder producing held/press flags, resolved
// directions, the HEX last-keycode register and a buffered press/release event stream.
module keycode_tracker
  import keymap_pkg::*;
#(
  parameter int NUM_SLOTS   = 2,
  parameter int NUM_PLAYERS = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [8*NUM_SLOTS-1:0]       keycode,
  output logic [5*NUM_PLAYERS-1:0]     held,
  output logic [5*NUM_PLAYERS-1:0]     press,
  output logic [3*NUM_PLAYERS-1:0]     dir,
  output logic [7:0]                   last_keycode,
  output logic                         ev_valid,
  output logic [EV_W-1:0]              ev_data,
  input  logic                         ev_ready,
  output logic                         ev_overflow
);

  localparam int NA = NUM_ACTIONS * NUM_PLAYERS;

  logic [NA-1:0]          hit_s;
  logic [NA-1:0]          held_r;
  logic [NA-1:0]          press_r;
  logic [NA-1:0]          rel_r;
  logic [7:0]             last_keycode_r;
  logic [NA-1:0]          press_pend_r;
  logic [NA-1:0]          rel_pend_r;
  logic [NA-1:0]          press_pend_n_s;
  logic [NA-1:0]          rel_pend_n_s;
  logic                   overflow_r;
  logic                   overflow_hit_s;
  logic [NA-1:0]          sel_hot_s;
  logic [PLAYER_W-1:0]    sel_player_s;
  logic [ACTION_W-1:0]    sel_action_s;
  logic                   sel_press_s;
  logic                   emit_s;
  logic [NA-1:0]          clr_p_s;
  logic [NA-1:0]          clr_r_s;
  logic                   push_ready_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [NUM_PLAYERS-1:0][1:0]       last_dir_r;
  logic [NUM_PLAYERS-1:0][1:0]       last_dir_n_s;
  logic [DIR_W*NUM_PLAYERS-1:0]      dir_r;
  logic [DIR_W*NUM_PLAYERS-1:0]      dir_n_s;

  always_comb begin
    hit_s = {NA{1'b0}};
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int a = 0; a < NUM_ACTIONS; a++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          hit_s[p*NUM_ACTIONS+a] = hit_s[p*NUM_ACTIONS+a] |
            ((keycode[s*8 +: 8] != 8'h00) && (keycode[s*8 +: 8] == KEYMAP[p][a]));
        end
      end
    end
  end

  // Registered held flags with rise/fall pulses; the pulses feed the pending bits next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_r         <= {NA{1'b0}};
      press_r        <= {NA{1'b0}};
      rel_r          <= {NA{1'b0}};
      last_keycode_r <= 8'h00;
    end else begin
      held_r  <= hit_s;
      press_r <= hit_s & ~held_r;
      rel_r   <= ~hit_s & held_r;
      if (keycode[7:0] != 8'h00) last_keycode_r <= keycode[7:0];
    end
  end

  // Descending scan so the lowest pending index ends up selected.
  always_comb begin
    sel_hot_s    = {NA{1'b0}};
    sel_player_s = {PLAYER_W{1'b0}};
    sel_action_s = {ACTION_W{1'b0}};
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      for (int a = NUM_ACTIONS - 1; a >= 0; a--) begin
        if (press_pend_r[p*NUM_ACTIONS+a] | rel_pend_r[p*NUM_ACTIONS+a]) begin
          sel_hot_s    = NA'(1) << (p*NUM_ACTIONS + a);
          sel_player_s = PLAYER_W'(p);
          sel_action_s = ACTION_W'(a);
        end else begin
          sel_hot_s = sel_hot_s;
        end
      end
    end
    sel_press_s = |(press_pend_r & sel_hot_s);
    emit_s      = (|(press_pend_r | rel_pend_r)) & push_ready_s;
    if (emit_s) begin
      clr_p_s = sel_press_s ? sel_hot_s : {NA{1'b0}};
      clr_r_s = sel_press_s ? {NA{1'b0}} : sel_hot_s;
    end else begin
      clr_p_s = {NA{1'b0}};
      clr_r_s = {NA{1'b0}};
    end
    press_pend_n_s = (press_pend_r & ~clr_p_s) | press_r;
    rel_pend_n_s   = (rel_pend_r & ~clr_r_s) | rel_r;
    overflow_hit_s = (|(press_r & press_pend_r & ~clr_p_s)) |
                     (|(rel_r & rel_pend_r & ~clr_r_s));
  end

  // Pending edge bits and the sticky coalescing flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      press_pend_r <= {NA{1'b0}};
      rel_pend_r   <= {NA{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      press_pend_r <= press_pend_n_s;
      rel_pend_r   <= rel_pend_n_s;
      if (overflow_hit_s) overflow_r <= 1'b1;
    end
  end

  always_comb begin
    last_dir_n_s = last_dir_r;
    dir_n_s      = {(DIR_W*NUM_PLAYERS){1'b0}};
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      logic [NUM_DIRS-1:0] dpress;
      logic [NUM_DIRS-1:0] dheld;
      logic [DIR_W-1:0]    lowest;
      dpress = press_r[p*NUM_ACTIONS +: NUM_DIRS];
      dheld  = held_r[p*NUM_ACTIONS +: NUM_DIRS];
      lowest = DIR_NONE;
      for (int a = NUM_DIRS - 1; a >= 0; a--) begin
        last_dir_n_s[p] = dpress[a] ? 2'(a) : last_dir_n_s[p];
        lowest          = dheld[a] ? DIR_W'(a + 1) : lowest;
      end
      if (dheld[last_dir_n_s[p]]) begin
        dir_n_s[p*DIR_W +: DIR_W] = {1'b0, last_dir_n_s[p]} + 3'd1;
      end else begin
        dir_n_s[p*DIR_W +: DIR_W] = lowest;
      end
    end
  end

  // Last-pressed direction memory and the resolved direction outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_dir_r <= '0;
      dir_r      <= {(DIR_W*NUM_PLAYERS){1'b0}};
    end else begin
      last_dir_r <= last_dir_n_s;
      dir_r      <= dir_n_s;
    end
  end

  kt_sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (Clk),
    .rst        (Reset),
    .push       (emit_s),
    .push_data  (pack_event(sel_player_s, sel_action_s, sel_press_s)),
    .push_ready (push_ready_s),
    .pop_ready  (ev_ready),
    .pop_valid  (ev_valid),
    .pop_data   (ev_data),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  assign held         = held_r;
  assign press        = press_r;
  assign dir          = dir_r;
  assign last_keycode = last_keycode_r;
  assign ev_overflow  = overflow_r;

  logic unused_s;
  assign unused_s = fifo_full_s ^ fifo_empty_s;

endmodule

// File: doc/keycode_tracker.md
# keycode_tracker

Parametrised keyboard front-end between the keycode PIO from the Nios II USB driver and the game logic. It replaces the single-key, single-player left/right/up/down compares in the top level with several things:
- multi-slot keycode decoding for several players;
- registered held flags and one-cycle press pulses;
- last-pressed direction resolution;
- a buffered press/release event stream with ready/valid handshake.

It also keeps the last-nonzero-keycode register used by the HEX display.

## Interface
Parameters:
- NUM_SLOTS, 2, number of simultaneous 8-bit keycodes packed in `keycode` (slot 0 = bits 7:0).
- NUM_PLAYERS, 2, players decoded (1..2), mapped by the package keymap.
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2).

Ports:
- Clk, in, 1: single system clock (CLOCK_50 domain). One clock.
- Reset, in, 1: synchronous, active-high.
- keycode, in, 8*NUM_SLOTS: raw keycode word from the PIO; 0x00 in a slot = empty.
- held, out, 5*NUM_PLAYERS: registered per-action held flags, index player*5+action.
- press, out, 5*NUM_PLAYERS: one-cycle pulse on a 0→1 transition of `held`.
- dir, out, 3*NUM_PLAYERS: resolved direction per player (dir_e).
- last_keycode, out, 8: last nonzero slot-0 keycode.
- ev_valid, out, 1: event FIFO non-empty.
- ev_data, out, 5: {player[0], action[2:0], is_press}; stable while ev_valid && !ev_ready.
- ev_ready, in, 1: consumer accepts the head entry when high with ev_valid.
- ev_overflow, out, 1: sticky; set when an edge is coalesced into an already-pending bit. Cleared only by Reset.

## Operation
- Decode: hit[p*5+a] is set when any slot equals KEYMAP[p][a]. Empty slots (0x00) never match. `held` is hit registered.
- press = held & ~held_d, where held_d is `held` delayed by one cycle.
- Edges set pending bits press_pend or rel_pend (one bit per action index).
  - If an edge lands on an already-set pending bit of the same kind, that bit stays set and ev_overflow is set.
  - A press and a release of the same action may both be pending.
- Emit: at most one FIFO push per cycle, when the FIFO is not full. Selection:
  - lowest index with any pending bit;
  - for that index, the press is emitted before the release;
  - the emitted pending bit clears in that cycle.
  - An edge arriving on the same bit in the same cycle it is emitted re-sets it; this does not count as overflow.
- FIFO: push and pop allowed in the same cycle, including when full. A pop frees a slot in that same cycle.
- dir: each player keeps a 2-bit last-pressed direction register, updated on any direction press pulse.
  - If several direction presses occur in the same cycle, the lowest action index wins.
  - dir = last-pressed if it is still held; otherwise the lowest-index held direction; otherwise NONE.
  - The bomb key does not affect dir.
- last_keycode loads slot 0 when it is nonzero; otherwise it holds its value.

## Timing
- Reset values: held, press, dir(NONE), last_keycode, ev_valid, ev_overflow, all pending bits and FIFO pointers are all 0. Reset mid-operation discards queued events.
- Latency from keycode change at edge t:
  - held, press and last_keycode at t+1;
  - dir at t+2;
  - pending set at t+2, ev_valid at t+3 earliest.
- Throughput: 1 event/cycle. A burst of k simultaneous edges drains in k cycles.
- A full FIFO with ev_ready=0 blocks emission; pending bits are retained and nothing is lost except by coalescing.

## Structure
- Package keymap_pkg holds:
  - action_e enum (UP=0, DOWN=1, LEFT=2, RIGHT=3, BOMB=4);
  - dir_e enum (NONE=0, UP, DOWN, LEFT, RIGHT);
  - KEYMAP constant: P0 W/S/A/D/Space = 1A/16/04/07/2C; P1 Up/Down/Left/Right/Enter = 52/51/50/4F/28;
  - the event field widths.
- One sub-module, kt_sync_fifo: parametrised width/depth, registered count, full/empty flags, same-cycle push/pop.

## Test plan
- Reset with keycode=0x001A → after release of Reset, all outputs 0; one cycle later held[UP]=1.
- keycode 0x0000→0x001A → press[0] pulses exactly 1 cycle at t+1; event 5'b0_000_1 valid at t+3. Then 0x0000 → event 5'b0_000_0.
- keycode 0x5004 (A + Left arrow) → held[2] and held[7] set; events {0,LEFT,1} then {1,LEFT,1} on consecutive cycles with ev_ready=1.
- Dir resolution for P0 (dir field 0):
  - hold 0x04, then 0x0704 → dir=RIGHT;
  - drop to 0x0004 → dir=LEFT;
  - keycode 0 → dir=NONE.
- ev_ready=0 and 9 edges toggled with FIFO_DEPTH=8 → FIFO full with 1 pending, ev_overflow stays 0. Re-toggle a pending key → ev_overflow=1. Raise ev_ready → the remaining events drain in index order.
- keycode 0x002C then 0x0000 → last_keycode=0x2C and stays 0x2C.
